uart_pia: RTL

- Serial-terminal stand-in for the Apple-1 keyboard/display PIA, sitting between the CPU data bus and the host UART lines.
- Receives bytes on uart_rx into a small FIFO and presents them as KBD/KBDCR at 0xD010/0xD011.
- Transmits CPU writes to DSP at 0xD012 on uart_tx, reporting busy in DSP bit 7.
- Drives uart_cts for host flow control.
- Its dout feeds the CPU data-in mux for both the keyboard and display chip selects.

---
 rtl/apple1_pkg.sv | 24 ++
 rtl/uart_pia_if.sv | 14 +
 rtl/uart_byte_fifo.sv | 64 ++++++
 rtl/uart_pia.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apple1_pkg.sv
// Shared definitions for the Apple-1 serial PIA: register offsets, the UART
// FSM state encoding and the baud divider calculation.
package apple1_pkg;

  localparam logic KBD   = 1'b0;
  localparam logic KBDCR = 1'b1;
  localparam logic DSP   = 1'b0;
  localparam logic DSPCR = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Rounded clocks per 16x oversample tick; never below one clock.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = (clk_hz + 32'sd8 * baud) / (32'sd16 * baud);
    return (d < 32'sd1) ? 32'sd1 : d;
  endfunction

endpackage

// File: rtl/uart_pia_if.sv
// CPU-side bus of the serial PIA: chip selects, address bit, write strobe,
// write data and combinational read data.
interface uart_pia_if;
  logic       enable;
  logic       kbd_cs;
  logic       dsp_cs;
  logic       address;
  logic       w_en;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output enable, kbd_cs, dsp_cs, address, w_en, din, input dout);
  modport slave  (input enable, kbd_cs, dsp_cs, address, w_en, din, output dout);
endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with power-of-2 depth; push and pop in the same cycle both take
// effect, so a full FIFO accepts a byte when it is popped in that cycle.
module uart_byte_fifo #(
  parameter int DEPTH = 32'sd4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 32'sd1;

  logic [7:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Storage array and write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
      wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
    end
  end

  // Read pointer and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_pia.sv
// Apple-1 keyboard/display PIA replacement backed by an 8N1 UART.
// Optional UART_PIA_UPCASE_EN folds received lowercase letters to uppercase.
module uart_pia
  import apple1_pkg::*;
#(
  parameter int CLK_HZ        = 32'sd14000000,
  parameter int BAUD          = 32'sd115200,
  parameter int RX_FIFO_DEPTH = 32'sd4
) (
  input  logic       clk14,
  input  logic       rst_n,
  uart_pia_if.slave  bus,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       uart_cts
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int DIV_W = (DIV > 32'sd1) ? $clog2(DIV) : 32'sd1;
  localparam int CNT_W = $clog2(RX_FIFO_DEPTH) + 32'sd1;

  logic [DIV_W-1:0] div_cnt_r;
  logic             tick_s;

  logic        rx_meta_r, rx_sync_r, rx_prev_r, rx_fall_s;
  uart_state_e rx_state_r, rx_state_n;
  logic [3:0]  rx_phase_r;
  logic [7:0]  rx_shift_r;
  logic [2:0]  rx_cnt_r;
  logic        rx_wait_r;
  logic        rx_hit_s, rx_phase_clr_s, rx_shift_en_s, rx_cnt_clr_s;
  logic        rx_push_s, rx_wait_set_s, rx_wait_clr_s;
  logic [7:0]  rx_byte_s;

  logic             fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic [7:0]       fifo_head_s;
  logic             overrun_r;
  logic             rd_strobe_s, wr_strobe_s, pop_s, ovr_set_s, ovr_clr_s;
  logic [7:0]       dout_s;

  uart_state_e tx_state_r, tx_state_n;
  logic [3:0]  tx_phase_r;
  logic [7:0]  tx_shift_r;
  logic [2:0]  tx_cnt_r;
  logic        tx_out_r;
  logic        tx_busy_s, tx_load_s, tx_hit_s;
  logic        tx_phase_clr_s, tx_shift_en_s, tx_cnt_clr_s, tx_line_s;

  logic unused_ok_s;
  assign unused_ok_s = &{1'b0, fifo_head_s[7], bus.din[7]};

  assign tick_s = (div_cnt_r == DIV_W'(DIV - 32'sd1));

  // Shared 16x oversample tick divider.
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else if (tick_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Receive line synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  assign rx_fall_s = rx_prev_r & ~rx_sync_r;
  // Start bit is checked mid-bit (8 ticks); later bits are one full period apart.
  assign rx_hit_s  = tick_s & (rx_phase_r == ((rx_state_r == START) ? 4'd7 : 4'd15));

  // RX state register.
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r <= IDLE;
    end else begin
      rx_state_r <= rx_state_n;
    end
  end

  // RX next state and datapath controls.
  always_comb begin
    rx_state_n     = rx_state_r;
    rx_phase_clr_s = 1'b0;
    rx_shift_en_s  = 1'b0;
    rx_cnt_clr_s   = 1'b0;
    rx_push_s      = 1'b0;
    rx_wait_set_s  = 1'b0;
    rx_wait_clr_s  = 1'b0;
    case (rx_state_r)
      IDLE: begin
        if (rx_fall_s) begin
          rx_state_n     = START;
          rx_phase_clr_s = 1'b1;
        end else begin
          rx_state_n = IDLE;
        end
      end
      START: begin
        if (rx_hit_s) begin
          rx_phase_clr_s = 1'b1;
          rx_cnt_clr_s   = 1'b1;
          rx_state_n     = rx_sync_r ? IDLE : DATA;
        end else begin
          rx_state_n = START;
        end
      end
      DATA: begin
        if (rx_hit_s) begin
          rx_phase_clr_s = 1'b1;
          rx_shift_en_s  = 1'b1;
          rx_state_n     = (rx_cnt_r == 3'd7) ? STOP : DATA;
        end else begin
          rx_state_n = DATA;
        end
      end
      STOP: begin
        if (rx_wait_r) begin
          // Framing error: hold here until the line returns to idle.
          if (rx_sync_r) begin
            rx_state_n    = IDLE;
            rx_wait_clr_s = 1'b1;
          end else begin
            rx_state_n = STOP;
          end
        end else if (rx_hit_s) begin
          rx_phase_clr_s = 1'b1;
          if (rx_sync_r) begin
            rx_push_s  = 1'b1;
            rx_state_n = IDLE;
          end else begin
            rx_wait_set_s = 1'b1;
            rx_state_n    = STOP;
          end
        end else begin
          rx_state_n = STOP;
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  // RX phase counter, shift register, bit counter and framing-wait flag.
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      rx_phase_r <= 4'd0;
      rx_shift_r <= 8'h00;
      rx_cnt_r   <= 3'd0;
      rx_wait_r  <= 1'b0;
    end else begin
      if (rx_phase_clr_s) begin
        rx_phase_r <= 4'd0;
      end else if (tick_s) begin
        rx_phase_r <= rx_phase_r + 4'd1;
      end
      if (rx_shift_en_s) begin
        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
      end
      if (rx_cnt_clr_s) begin
        rx_cnt_r <= 3'd0;
      end else if (rx_shift_en_s) begin
        rx_cnt_r <= rx_cnt_r + 3'd1;
      end
      if (rx_wait_set_s) begin
        rx_wait_r <= 1'b1;
      end else if (rx_wait_clr_s) begin
        rx_wait_r <= 1'b0;
      end
    end
  end

  // Byte presented to the FIFO, optionally case-folded.
  always_comb begin
`ifdef UART_PIA_UPCASE_EN
    if ((rx_shift_r >= 8'h61) && (rx_shift_r <= 8'h7A)) begin
      rx_byte_s = rx_shift_r - 8'h20;
    end else begin
      rx_byte_s = rx_shift_r;
    end
`else
    rx_byte_s = rx_shift_r;
`endif
  end

  uart_byte_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_fifo (
    .clk       (clk14),
    .rst_n     (rst_n),
    .push      (rx_push_s),
    .push_data (rx_byte_s),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s),
    .head      (fifo_head_s)
  );

  assign uart_cts    = (fifo_count_s < CNT_W'(RX_FIFO_DEPTH - 32'sd1));
  assign rd_strobe_s = bus.enable & ~bus.w_en;
  assign wr_strobe_s = bus.enable & bus.w_en;
  assign pop_s       = rd_strobe_s & bus.kbd_cs & (bus.address == KBD) & ~fifo_empty_s;
  assign ovr_clr_s   = rd_strobe_s & bus.kbd_cs & (bus.address == KBDCR);
  assign ovr_set_s   = rx_push_s & fifo_full_s & ~pop_s;
  assign tx_busy_s   = (tx_state_r != IDLE);
  assign tx_load_s   = wr_strobe_s & bus.dsp_cs & (bus.address == DSP) & ~tx_busy_s;

  // Sticky overrun flag; a new drop wins over a clearing read.
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (ovr_set_s) begin
      overrun_r <= 1'b1;
    end else if (ovr_clr_s) begin
      overrun_r <= 1'b0;
    end
  end

  // Register read mux.
  always_comb begin
    dout_s = 8'h00;
    if (bus.kbd_cs) begin
      case (bus.address)
        KBD:     dout_s = fifo_empty_s ? 8'h00 : {1'b1, fifo_head_s[6:0]};
        KBDCR:   dout_s = {~fifo_empty_s, overrun_r, 6'b000000};
        default: dout_s = 8'h00;
      endcase
    end else if (bus.dsp_cs) begin
      case (bus.address)
        DSP:     dout_s = {tx_busy_s, 7'b0000000};
        DSPCR:   dout_s = 8'h00;
        default: dout_s = 8'h00;
      endcase
    end else begin
      dout_s = 8'h00;
    end
  end

  assign bus.dout = dout_s;
  assign tx_hit_s = tick_s & (tx_phase_r == 4'd15);

  // TX state register.
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r <= IDLE;
    end else begin
      tx_state_r <= tx_state_n;
    end
  end

  // TX next state, line level and datapath controls.
  always_comb begin
    tx_state_n     = tx_state_r;
    tx_phase_clr_s = 1'b0;
    tx_shift_en_s  = 1'b0;
    tx_cnt_clr_s   = 1'b0;
    tx_line_s      = 1'b1;
    case (tx_state_r)
      IDLE: begin
        tx_line_s = 1'b1;
        if (tx_load_s) begin
          tx_state_n     = START;
          tx_phase_clr_s = 1'b1;
        end else begin
          tx_state_n = IDLE;
        end
      end
      START: begin
        tx_line_s = 1'b0;
        if (tx_hit_s) begin
          tx_state_n     = DATA;
          tx_phase_clr_s = 1'b1;
          tx_cnt_clr_s   = 1'b1;
        end else begin
          tx_state_n = START;
        end
      end
      DATA: begin
        tx_line_s = tx_shift_r[0];
        if (tx_hit_s) begin
          tx_phase_clr_s = 1'b1;
          tx_shift_en_s  = 1'b1;
          tx_state_n     = (tx_cnt_r == 3'd7) ? STOP : DATA;
        end else begin
          tx_state_n = DATA;
        end
      end
      STOP: begin
        tx_line_s  = 1'b1;
        tx_state_n = tx_hit_s ? IDLE : STOP;
      end
      default: begin
        tx_line_s  = 1'b1;
        tx_state_n = IDLE;
      end
    endcase
  end

  // TX phase counter, shift register, bit counter and registered line.
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      tx_phase_r <= 4'd0;
      tx_shift_r <= 8'h00;
      tx_cnt_r   <= 3'd0;
      tx_out_r   <= 1'b1;
    end else begin
      if (tx_phase_clr_s) begin
        tx_phase_r <= 4'd0;
      end else if (tick_s) begin
        tx_phase_r <= tx_phase_r + 4'd1;
      end
      if (tx_load_s) begin
        tx_shift_r <= {1'b0, bus.din[6:0]};
      end else if (tx_shift_en_s) begin
        tx_shift_r <= {1'b0, tx_shift_r[7:1]};
      end
      if (tx_cnt_clr_s) begin
        tx_cnt_r <= 3'd0;
      end else if (tx_shift_en_s) begin
        tx_cnt_r <= tx_cnt_r + 3'd1;
      end
      tx_out_r <= tx_line_s;
    end
  end

  assign uart_tx = tx_out_r;

endmodule
